wptr_full: RTL

Write-side pointer and status block of the asynchronous FIFO, running entirely in the write clock domain. It holds the binary and Gray write pointers, supplies the memory write address, and compares against the read pointer, which has already been synchronized into the write domain. From that comparison it produces registered full, almost-full and occupancy outputs. It is the write-side counterpart of the read-pointer/empty logic and uses the same pointer encoding: ASIZE+1 bits, with the MSB as the wrap bit.

---
 rtl/wptr_full_if.sv | 29 ++
 rtl/wptr_full.sv | 78 +++++++
 2 files changed

// File: rtl/wptr_full_if.sv
// Write-side pointer/status bundle of the async FIFO.
// wovf/wovf_cnt exist only when WPTR_FULL_OVF_EN is defined.
interface wptr_full_if #(
  parameter int ASIZE = 5
);
  // Handshake: winc is a request; a write is taken on a wclk edge where
  // winc && !wfull. There is no other ready signal; wfull acts as ~ready.
  logic             winc;
  logic [ASIZE:0]   wq2_rptr;
  logic [ASIZE-1:0] waddr;
  logic [ASIZE:0]   wptr;
  logic             wfull;
  logic             walmostfull;
  logic [ASIZE:0]   wlevel;
`ifdef WPTR_FULL_OVF_EN
  logic             wovf;
  logic [7:0]       wovf_cnt;

  modport master (output winc, wq2_rptr,
                  input  waddr, wptr, wfull, walmostfull, wlevel, wovf, wovf_cnt);
  modport slave  (input  winc, wq2_rptr,
                  output waddr, wptr, wfull, walmostfull, wlevel, wovf, wovf_cnt);
`else
  modport master (output winc, wq2_rptr,
                  input  waddr, wptr, wfull, walmostfull, wlevel);
  modport slave  (input  winc, wq2_rptr,
                  output waddr, wptr, wfull, walmostfull, wlevel);
`endif
endinterface

// File: rtl/wptr_full.sv
// Write-domain pointer, full/almost-full and occupancy logic of the async FIFO.
// Optional overflow tracking (wovf, wovf_cnt) is enabled by WPTR_FULL_OVF_EN.
module wptr_full #(
  parameter int ASIZE                 = 5,
  parameter int ALMOST_FULL_THRESHOLD = 2
) (
  input  logic       wclk,
  input  logic       wrst,
  wptr_full_if.slave bus
);
  localparam logic [ASIZE:0] DEPTH     = (ASIZE+1)'(1) << ASIZE;
  localparam logic [ASIZE:0] FULL_MASK = (ASIZE+1)'(3) << (ASIZE-1);
  localparam logic [ASIZE:0] AF_TH     = (ASIZE+1)'(ALMOST_FULL_THRESHOLD);

  logic [ASIZE:0] wbin, wptr_q, wlevel_q;
  logic           wfull_q, walmostfull_q;
  logic           accept;
  logic [ASIZE:0] wbinnext, wgraynext, rbin_s, levelnext, freenext;

  assign accept    = bus.winc & ~wfull_q;
  assign wbinnext  = wbin + {{ASIZE{1'b0}}, accept};
  assign wgraynext = (wbinnext >> 1) ^ wbinnext;

  // Gray-to-binary: each bit is the XOR of itself and all higher Gray bits.
  always_comb begin
    rbin_s = '0;
    for (int k = 0; k <= ASIZE; k++) begin
      rbin_s[k] = ^(bus.wq2_rptr >> k);
    end
  end

  assign levelnext = wbinnext - rbin_s;
  assign freenext  = DEPTH - levelnext;

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin          <= '0;
      wptr_q        <= '0;
      wfull_q       <= 1'b0;
      walmostfull_q <= 1'b0;
      wlevel_q      <= '0;
    end else begin
      wbin          <= wbinnext;
      wptr_q        <= wgraynext;
      // Full when the next write pointer is one lap ahead of the read pointer.
      wfull_q       <= (wgraynext == (bus.wq2_rptr ^ FULL_MASK));
      walmostfull_q <= (freenext <= AF_TH);
      wlevel_q      <= levelnext;
    end
  end

  assign bus.waddr       = wbin[ASIZE-1:0];
  assign bus.wptr        = wptr_q;
  assign bus.wfull       = wfull_q;
  assign bus.walmostfull = walmostfull_q;
  assign bus.wlevel      = wlevel_q;

`ifdef WPTR_FULL_OVF_EN
  logic       wovf_q;
  logic [7:0] wovf_cnt_q;
  logic       drop;

  assign drop = bus.winc & wfull_q;

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wovf_q     <= 1'b0;
      wovf_cnt_q <= '0;
    end else if (drop) begin
      wovf_q     <= 1'b1;
      if (wovf_cnt_q != 8'hFF) wovf_cnt_q <= wovf_cnt_q + 8'd1;
    end
  end

  assign bus.wovf     = wovf_q;
  assign bus.wovf_cnt = wovf_cnt_q;
`endif
endmodule
